// File: rtl/seq_detect_ctrl.sv
// Run controller around a programmable serial pattern detector with a Mealy hit output.
// Host latches the pattern/length/mode/target on start; done/done_ack closes a run.
module seq_detect_ctrl #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               x,
   output logic               hit,
   output logic [CNT_W-1:0]   count,
   output logic               busy,
   output logic               done,
   input  logic               done_ack
);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len_m1;
   logic [CNT_W-1:0]   cnt_inc;
   logic               match;
   logic               accept;

   assign accept  = start && (cfg_len != '0);
   assign window  = {hist_q, x};
   assign len_m1  = len_q - LEN_W'(1);
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (LEN_W'(i) < len_q);
   end

   // fill gate keeps a cleared history from matching all-zero patterns
   assign match = (fill_q >= len_m1) && (((window ^ pat_q) & mask) == '0);
   assign hit   = (state_q == ARMED) && match && !abort;
   assign busy  = (state_q == ARMED);
   assign done  = (state_q == DONE);
   assign count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ARMED;
         ARMED: begin
            if (abort)
               state_d = IDLE;
            else if (hit && (tgt_q != '0) && (cnt_inc == tgt_q))
               state_d = DONE;
         end
         DONE:    if (abort || done_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q  <= '0;
         len_q  <= '0;
         ovl_q  <= 1'b0;
         tgt_q  <= '0;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            pat_q  <= cfg_pattern;
            len_q  <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_q  <= cfg_overlap;
            tgt_q  <= cfg_target;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
         end
      end else if ((state_q == ARMED) && !abort) begin
         hist_q <= window[MAX_LEN-2:0];
         if (fill_q != FILL_MAX) fill_q <= fill_q + LEN_W'(1);
         if (hit) begin
            if (cnt_q != '1) cnt_q <= cnt_inc;
            // non-overlap mode: the completing bit must not seed the next match
            if (!ovl_q) begin
               hist_q <= '0;
               fill_q <= '0;
            end
         end
      end
   end

endmodule
